// File: rtl/pipe_sched.sv
// pipe_sched: three-slot in-order stage sequencer with an output register and start pulses.
// Optional performance counters are enabled by defining PIPE_SCHED_PERF_EN.
module pipe_sched (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       st1_exec,
    output logic       st2_exec,
    output logic       st3_exec,
    output logic [7:0] st1_data,
    output logic [7:0] st2_data,
    output logic [7:0] st3_data,
    input  logic       st1_done,
    input  logic       st2_done,
    input  logic       st3_done,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    input  logic       flush,
    output logic       busy,
    output logic [15:0] issue_cnt,
    output logic [15:0] stall_cnt
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HELD = 2'd2} state_t;

    state_t     r_st1, r_st2, r_st3;
    state_t     w_nx1, w_nx2, w_nx3;
    logic [7:0] r_d1, r_d2, r_d3, r_out_data;
    logic       r_ex1, r_ex2, r_ex3, r_out_valid;
    logic       w_want1, w_want2, w_want3;
    logic       w_leave1, w_leave2, w_leave3;
    logic       w_free1, w_free2, w_free3;
    logic       w_out_free, w_acc;

    // A slot wants to move once its done has been seen (RUN+done now, or already HELD).
    assign w_want1 = (r_st1 == RUN && st1_done) || r_st1 == HELD;
    assign w_want2 = (r_st2 == RUN && st2_done) || r_st2 == HELD;
    assign w_want3 = (r_st3 == RUN && st3_done) || r_st3 == HELD;

    // Free-next chain resolves from the output backwards so a full pipe can advance in lockstep.
    assign w_out_free = !r_out_valid || out_ready;
    assign w_leave3   = w_want3 && w_out_free;
    assign w_free3    = r_st3 == IDLE || w_leave3;
    assign w_leave2   = w_want2 && w_free3;
    assign w_free2    = r_st2 == IDLE || w_leave2;
    assign w_leave1   = w_want1 && w_free2;
    assign w_free1    = r_st1 == IDLE || w_leave1;

    assign in_ready = rst && !flush && w_free1;
    assign w_acc    = in_valid && in_ready;

    function automatic state_t f_next(state_t s, logic enter, logic leave, logic done);
        return enter ? RUN : leave ? IDLE : (s == RUN && done) ? HELD : s;
    endfunction

    always_comb begin
        w_nx1 = f_next(r_st1, w_acc, w_leave1, st1_done);
        w_nx2 = f_next(r_st2, w_leave1, w_leave2, st2_done);
        w_nx3 = f_next(r_st3, w_leave2, w_leave3, st3_done);
        if (flush) begin
            w_nx1 = IDLE;
            w_nx2 = IDLE;
            w_nx3 = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_st1 <= IDLE;
            r_st2 <= IDLE;
            r_st3 <= IDLE;
        end else begin
            r_st1 <= w_nx1;
            r_st2 <= w_nx2;
            r_st3 <= w_nx3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_d1        <= '0;
            r_d2        <= '0;
            r_d3        <= '0;
            r_ex1       <= 1'b0;
            r_ex2       <= 1'b0;
            r_ex3       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_ex1 <= !flush && w_acc;
            r_ex2 <= !flush && w_leave1;
            r_ex3 <= !flush && w_leave2;
            if (!flush && w_acc)
                r_d1 <= in_data;
            if (!flush && w_leave1)
                r_d2 <= r_d1;
            if (!flush && w_leave2)
                r_d3 <= r_d2;
            if (flush)
                r_out_valid <= 1'b0;
            else if (w_leave3) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_d3;
            end else if (out_ready)
                r_out_valid <= 1'b0;
        end
    end

    assign st1_exec  = r_ex1;
    assign st2_exec  = r_ex2;
    assign st3_exec  = r_ex3;
    assign st1_data  = r_d1;
    assign st2_data  = r_d2;
    assign st3_data  = r_d3;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_st1 != IDLE || r_st2 != IDLE || r_st3 != IDLE || r_out_valid;

`ifdef PIPE_SCHED_PERF_EN
    logic [15:0] r_issue, r_stall;

    // Saturating counters survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issue <= '0;
            r_stall <= '0;
        end else begin
            if (w_acc && r_issue != 16'hFFFF)
                r_issue <= r_issue + 16'd1;
            if (in_valid && !in_ready && r_stall != 16'hFFFF)
                r_stall <= r_stall + 16'd1;
        end
    end

    assign issue_cnt = r_issue;
    assign stall_cnt = r_stall;
`else
    assign issue_cnt = '0;
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_sched.sv
// tb_pipe_sched: scoreboard bench for pipe_sched; directed scenarios plus randomized traffic.
module tb_pipe_sched;
    logic        clk = 1'b0, rst = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic [7:0]  in_data = '0;
    logic        st1_done = 1'b0, st2_done = 1'b0, st3_done = 1'b0;
    logic        in_ready, st1_exec, st2_exec, st3_exec, out_valid, busy;
    logic [7:0]  st1_data, st2_data, st3_data, out_data;
    logic [15:0] issue_cnt, stall_cnt;

    pipe_sched dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .st1_exec(st1_exec), .st2_exec(st2_exec), .st3_exec(st3_exec),
        .st1_data(st1_data), .st2_data(st2_data), .st3_data(st3_data),
        .st1_done(st1_done), .st2_done(st2_done), .st3_done(st3_done),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .flush(flush), .busy(busy), .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int pass_n = 0, tot_n = 0;
    int cyc = 0;
    logic [7:0] acc[$];
    int ps[3];
    int po = 0, out_cnt = 0, ex2_cnt = 0, iss_exp = 0, stall_exp = 0;
    int out_cyc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(posedge clk) cyc++;

    // Reference: every accepted token visits stages 1..3 then the output, in acceptance order.
    always @(negedge clk) begin
        logic [2:0] ex;
        logic [7:0] dd[3];
        ex = {st3_exec, st2_exec, st1_exec};
        dd[0] = st1_data; dd[1] = st2_data; dd[2] = st3_data;
        if (!rst) begin
            for (int k = 0; k < 3; k++) ps[k] = acc.size();
            po = acc.size();
            iss_exp = 0;
            stall_exp = 0;
        end else begin
            chk("busy", busy, (acc.size() - po) != 0);
            for (int k = 0; k < 3; k++)
                if (ex[k]) begin
                    if (ps[k] < acc.size()) chk($sformatf("st%0d_data", k + 1), dd[k], acc[ps[k]]);
                    else chk($sformatf("st%0d_exec_extra", k + 1), ex[k], 1'b0);
                    ps[k]++;
                end
            if (st2_exec) ex2_cnt++;
            if (out_valid && out_ready) begin
                if (po < acc.size()) chk("out_data", out_data, acc[po]);
                else chk("out_valid_extra", out_valid, 1'b0);
                po++;
                out_cnt++;
                out_cyc.push_back(cyc);
            end
            if (in_valid && in_ready) begin
                acc.push_back(in_data);
                iss_exp++;
            end
            if (in_valid && !in_ready) stall_exp++;
            if (flush) begin
                for (int k = 0; k < 3; k++) ps[k] = acc.size();
                po = acc.size();
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int n, input int budget);
        int c = 0;
        while (out_cnt < n && c < budget) begin
            step();
            c++;
        end
        chk("wait_out", out_cnt >= n, 1'b1);
    endtask

    task automatic chk_cnt(input string nm);
`ifdef PIPE_SCHED_PERF_EN
        chk({nm, "_issue"}, issue_cnt, iss_exp);
        chk({nm, "_stall"}, stall_cnt, stall_exp);
`else
        chk({nm, "_issue"}, issue_cnt, 0);
        chk({nm, "_stall"}, stall_cnt, 0);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int o, b2, k, drops, e;
        logic [7:0] seq;
        repeat (2) step();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_exec", {st3_exec, st2_exec, st1_exec}, 3'b000);
        chk("rst_data", {st1_data, st2_data, st3_data, out_data}, 32'h0);
        chk("rst_cnt", {issue_cnt, stall_cnt}, 32'h0);
        step();
        rst = 1'b1;
        {st1_done, st2_done, st3_done} = 3'b111;
        out_ready = 1'b1;

        // single token latency
        in_valid = 1'b1; in_data = 8'h05;
        @(negedge clk);
        chk("lat_in_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        @(negedge clk); chk("lat_ex1", {st3_exec, st2_exec, st1_exec}, 3'b001);
        step(); @(negedge clk); chk("lat_ex2", {st3_exec, st2_exec, st1_exec}, 3'b010);
        step(); @(negedge clk); chk("lat_ex3", {st3_exec, st2_exec, st1_exec}, 3'b100);
        step(); @(negedge clk);
        chk("lat_out", {out_valid, out_data}, {1'b1, 8'h05});
        chk("lat_ex_none", {st3_exec, st2_exec, st1_exec}, 3'b000);
        step(); step();

        // back-to-back stream
        o = out_cnt; drops = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            @(negedge clk);
            if (!in_ready) drops++;
            step();
        end
        in_valid = 1'b0;
        wait_out(o + 16, 40);
        chk("stream_drops", drops, 0);
        chk("stream_rate", out_cyc[o + 15] - out_cyc[o], 15);

        // stage 2 slow on A0, A1 must wait in stage 1
        b2 = ex2_cnt; o = out_cnt;
        st2_done = 1'b0;
        in_valid = 1'b1; in_data = 8'hA0; step();
        in_data = 8'hA1; step();
        in_valid = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("slow_ex2_once", ex2_cnt - b2, 1);
        chk("slow_in_ready", in_ready, 1'b0);
        st2_done = 1'b1;
        wait_out(o + 2, 20);
        chk("slow_ex2_twice", ex2_cnt - b2, 2);
        step();

        // output stalled: only four tokens fit
        out_ready = 1'b0; k = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_data = 8'hB0 + 8'(k);
            @(negedge clk);
            if (in_ready) k++;
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_accepted", k, 4);
        chk("full_in_ready", in_ready, 1'b0);
        chk_cnt("full");
        o = out_cnt;
        out_ready = 1'b1;
        wait_out(o + 4, 20);

        // flush with tokens in flight and a simultaneous offer
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'hC0 + 8'(i); step();
        end
        in_data = 8'hD0; flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 1'b0);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_busy", busy, 1'b0);
        e = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (st1_exec || st2_exec || st3_exec || busy) e++;
            step();
        end
        chk("flush_quiet", e, 0);

        // reset mid-stream
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'hE0 + 8'(i); step();
        end
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ctl", {in_ready, busy, out_valid, st3_exec, st2_exec, st1_exec}, 6'b0);
        chk("mid_rst_data", {st1_data, st2_data, st3_data, out_data}, 32'h0);
        chk("mid_rst_cnt", {issue_cnt, stall_cnt}, 32'h0);
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        in_valid = 1'b1; in_data = 8'h33;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("post_rst_out", {out_valid, out_data}, {1'b1, 8'h33});
        chk_cnt("post_rst");

        // randomized traffic
        seq = 8'h40;
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = seq;
            out_ready = ($urandom_range(0, 3) != 0);
            st1_done  = ($urandom_range(0, 2) != 0);
            st2_done  = ($urandom_range(0, 2) != 0);
            st3_done  = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            @(negedge clk);
            if (in_valid && in_ready) seq++;
            step();
        end
        {in_valid, flush} = 2'b00;
        {st1_done, st2_done, st3_done, out_ready} = 4'hF;
        k = 0;
        while (busy && k < 50) begin
            step();
            k++;
        end
        @(negedge clk);
        chk("drain_busy", busy, 1'b0);
        chk("drain_all_out", po, acc.size());
        chk_cnt("final");
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule

// File: doc/pipe_sched.md
PIPE_SCHED -- requirements
Module: pipe_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: upstream offers in_data.
REQ-004 SHALL have port in_data, input, 8 bits: token to sequence.
REQ-005 SHALL have port in_ready, output, 1 bit: token accepted at an edge where in_valid&&in_ready.
REQ-006 SHALL have ports st1_exec/st2_exec/st3_exec, output, 1 bit each: one-cycle start pulse to stage N.
REQ-007 SHALL have ports st1_data/st2_data/st3_data, output, 8 bits each: token currently owned by stage N.
REQ-008 SHALL have ports st1_done/st2_done/st3_done, input, 1 bit each: stage N finished its current token.
REQ-009 SHALL have port out_valid, output, 1 bit, and port out_data, output, 8 bits: completed token.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream takes out_data.
REQ-011 SHALL have port flush, input, 1 bit: synchronous pipeline clear.
REQ-012 SHALL have port busy, output, 1 bit: any token in flight.
REQ-013 SHALL have ports issue_cnt and stall_cnt, output, 16 bits each: performance counters (see Configuration).

Function
REQ-014 Each stage slot SHALL hold one state: IDLE (empty), RUN (exec issued, awaiting done), HELD (done seen, successor full).
REQ-015 A slot SHALL be "free next" when IDLE, or when its token leaves at the same edge.
REQ-016 in_ready SHALL equal !flush && (stage 1 free next).
REQ-017 On acceptance, stage 1 SHALL enter RUN, load st1_data=in_data, and assert st1_exec in exactly the first cycle after the edge.
REQ-018 stN_done sampled high in RUN (including the st_exec cycle): the token SHALL move at that edge to stage N+1 (or output register for N=3) if free next, else to HELD.
REQ-019 HELD stage SHALL move its token at the first edge its successor is free next; stNd_data follows; successor's exec pulses in the next cycle.
REQ-020 stN_done in IDLE or HELD SHALL be ignored.
REQ-021 out_valid SHALL stay high with out_data stable until an edge with out_ready high.
REQ-022 Tokens SHALL never overtake; output order equals input order.
REQ-023 Minimum latency: acceptance edge E0 -> out_valid high after edge E3, with all done inputs high.
REQ-024 Full pipeline (3 slots + output register) with out_ready high and all done high SHALL sustain one token per cycle.
REQ-025 flush high at an edge SHALL set all slots IDLE, out_valid 0, no exec pulse next cycle; flush wins over simultaneous accept, done and out_ready.
REQ-026 busy SHALL be 1 whenever any slot is not IDLE or out_valid is 1.
REQ-027 stN_data SHALL hold last value when slot goes IDLE (don't-care to stages).

Reset
REQ-028 rst low SHALL immediately set all slots IDLE and force st*_exec, out_valid, busy, in_ready to 0; all st*_data, out_data, issue_cnt and stall_cnt to 0.
REQ-029 Reset asserted mid-operation SHALL discard all tokens; first acceptance possible at the first edge after rst deasserts.

Configuration
REQ-030 Macro PIPE_SCHED_PERF_EN defined: issue_cnt SHALL increment on each acceptance, stall_cnt on each edge with in_valid && !in_ready; both saturate at 16'hFFFF, cleared only by reset, not flush.
REQ-031 Macro undefined: issue_cnt and stall_cnt ports SHALL remain present and constant 0, no counter logic.

Verification
REQ-032 Single token 8'h05, all done tied high, out_ready high -> st1/st2/st3_exec pulse on consecutive cycles, out_data=8'h05 valid 3 edges after acceptance.
REQ-033 Stream 8'h00..8'h0F back-to-back, all done high -> 16 outputs in order at one per cycle, in_ready never drops.
REQ-034 out_ready low, 5 tokens offered -> 4 accepted (3 slots HELD + output), in_ready 0, stall_cnt counts (PERF_EN); release -> 4 outputs in order.
REQ-035 st2_done delayed 4 cycles for token 8'hA0 -> st2_exec single pulse, token 8'hA1 HELD in stage 1, no st2_exec until A0 moves.
REQ-036 flush while 3 tokens in flight, simultaneous in_valid -> out_valid 0, busy 0 next cycle, token not accepted, late stN_done ignored.
REQ-037 rst low mid-stream -> all outputs 0 immediately; after release, 8'h33 passes with 3-edge latency; counters restart at 0.
